// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: captures a parallel pattern and shifts it out MSB of the
// active length first, for repeat_cnt+1 back-to-back passes.
// Ports: clk, rst (async, active-high), start, pattern, len, repeat_cnt
// ("repeat" is a reserved word), x, bit_valid, busy, done.
// Optional macro SERIAL_PATTERN_GEN_MARK_EN adds output mark (last bit of pass).
module serial_pattern_gen #(
  parameter int PAT_W = 16,
  parameter int LEN_W = 5,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] repeat_cnt,
  output logic             x,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
`ifdef SERIAL_PATTERN_GEN_MARK_EN
  ,
  output logic             mark
`endif
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [PAT_W-1:0] sh;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rem;
  logic [REP_W-1:0] rep_q;
  logic [REP_W:0]   pass;
  logic [LEN_W-1:0] eff;
  logic [PAT_W-1:0] al;
  logic             mark_q;

  // Clamp the length, then left-align so the first bit sits at the MSB.
  always_comb begin
    eff = len;
    if (len > LEN_W'(PAT_W))
      eff = LEN_W'(PAT_W);
    al = pattern << (LEN_W'(PAT_W) - eff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sh        <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      rem       <= '0;
      rep_q     <= '0;
      pass      <= '0;
      x         <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mark_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (eff != '0) begin
              state     <= SHIFT;
              x         <= al[PAT_W-1];
              sh        <= al << 1;
              pat_q     <= al;
              len_q     <= eff;
              rem       <= eff - LEN_W'(1);
              rep_q     <= repeat_cnt;
              pass      <= '0;
              bit_valid <= 1'b1;
              busy      <= 1'b1;
              mark_q    <= (eff == LEN_W'(1));
            end else begin
              done <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (rem != '0) begin
            x      <= sh[PAT_W-1];
            sh     <= sh << 1;
            rem    <= rem - LEN_W'(1);
            mark_q <= (rem == LEN_W'(1));
          end else if (pass != {1'b0, rep_q}) begin
            // Reload for the next pass with no gap.
            pass   <= pass + 1'b1;
            x      <= pat_q[PAT_W-1];
            sh     <= pat_q << 1;
            rem    <= len_q - LEN_W'(1);
            mark_q <= (len_q == LEN_W'(1));
          end else begin
            state     <= IDLE;
            x         <= 1'b0;
            sh        <= '0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            mark_q    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_PATTERN_GEN_MARK_EN
  assign mark = mark_q;
`else
  logic unused_mark;
  assign unused_mark = mark_q;
`endif

endmodule
